// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg : shared serializer states and UART framing constants       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with registered full/empty flags       |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;
    logic             w_push;
    logic             w_pop;

    // A write while full is refused even if a pop frees a slot on the same edge.
    assign w_push = wr_en & ~full_q;
    assign w_pop  = rd_en & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (w_push) tail_q <= tail_q + PTR_W'(1);
            if (w_pop)  head_q <= head_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[tail_q] <= wr_data;
    end

    assign rd_data = mem_q[head_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +----------------------------------------------------------------------+
// | uart_tx_fifo : byte FIFO feeding an 8N1 UART transmitter             |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       busy,
    output logic       tx_out
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    tx_state_e      state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ovf_q;
    logic             w_pop;
    logic             w_bit_end;
    logic             w_has_data;
    logic [7:0]       w_rd_data;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign w_has_data = (w_count != '0);
    assign w_bit_end  = (tmr_q == TMR_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        w_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                idx_d = '0;
                if (w_has_data) begin
                    w_pop   = 1'b1;
                    shift_d = w_rd_data;
                    state_d = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    tmr_d   = '0;
                    state_d = DATA;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    tmr_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    tmr_d = '0;
                    // Chain straight into the next start bit to keep frames gap-free.
                    if (w_has_data) begin
                        w_pop   = 1'b1;
                        shift_d = w_rd_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line is a flop of the decoded state, so it trails the FSM by one cycle.
    always_comb begin
        tx_d = STOP_BIT;
        case (state_q)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_q[0];
            default: tx_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_q | (wr_en & w_full);
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE);
    assign tx_out   = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// +----------------------------------------------------------------------+
// | tb_uart_tx_fifo : self-checking bench for uart_tx_fifo               |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       busy;
    logic       tx_out;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];
    bit         mon_en = 1'b0;
    logic       prev_tx = 1'b1;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .busy     (busy),
        .tx_out   (tx_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Compares the line against a bit pattern, CPB cycles per bit; reports bad cycles per bit.
    task automatic check_line(input string name, input logic [19:0] bits, input int nbits);
        int bad;
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int c = 0; c < CPB; c++) begin
                if (tx_out !== bits[b]) bad++;
                tick();
            end
            chk($sformatf("%s bit%0d bad_cycles", name, b), bad, 0);
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("scoreboard drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        sb.delete();
        tick();
    endtask

    // Serial monitor: decodes frames mid-bit and pops the scoreboard.
    initial begin
        logic [7:0] got;
        logic [7:0] exp;
        forever begin
            tick();
            if (mon_en && prev_tx === 1'b1 && tx_out === 1'b0) begin
                repeat (CPB / 2) tick();
                chk("mon start bit", tx_out, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) tick();
                    got[i] = tx_out;
                end
                repeat (CPB) tick();
                chk("mon stop bit", tx_out, 1'b1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon frame: got 0x%0h expected no frame", got);
                end else begin
                    exp = sb.pop_front();
                    chk("mon data", got, exp);
                end
            end
            prev_tx = tx_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] line;

        vecs[0] = '{data: 8'h55, frame: 10'b1_01010101_0};
        vecs[1] = '{data: 8'hA3, frame: 10'b1_10100011_0};
        vecs[2] = '{data: 8'h0F, frame: 10'b1_00001111_0};
        vecs[3] = '{data: 8'h00, frame: 10'b1_00000000_0};
        vecs[4] = '{data: 8'hFF, frame: 10'b1_11111111_0};

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (3) tick();
        chk("reset tx_out", tx_out, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset empty", empty, 1'b1);
        chk("reset full", full, 1'b0);
        chk("reset overflow", overflow, 1'b0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // Single frames from idle: exact latency and bit timing.
        for (int i = 0; i < 5; i++) begin
            sb.push_back(vecs[i].data);
            write_byte(vecs[i].data);
            chk($sformatf("v%0d tx after write", i), tx_out, 1'b1);
            tick();
            chk($sformatf("v%0d tx one edge later", i), tx_out, 1'b1);
            chk($sformatf("v%0d busy", i), busy, 1'b1);
            tick();
            check_line($sformatf("v%0d", i), {10'h3FF, vecs[i].frame}, 10);
            chk($sformatf("v%0d busy after stop", i), busy, 1'b0);
            chk($sformatf("v%0d tx idle", i), tx_out, 1'b1);
            chk($sformatf("v%0d empty", i), empty, 1'b1);
        end

        // Back-to-back writes: 80 contiguous frame cycles.
        sb.push_back(8'hA3);
        sb.push_back(8'h0F);
        wr_en   = 1'b1;
        wr_data = 8'hA3;
        tick();
        wr_data = 8'h0F;
        tick();
        wr_en = 1'b0;
        tick();
        line = {vecs[2].frame, vecs[1].frame};
        check_line("b2b", line, 20);
        repeat (2) tick();
        chk("b2b busy after", busy, 1'b0);

        // Six consecutive writes into a depth-4 FIFO: sixth is dropped.
        for (int k = 0; k < 6; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h11 * (k + 1));
            if (k < 5) sb.push_back(8'(8'h11 * (k + 1)));
            tick();
        end
        wr_en = 1'b0;
        chk("ovf full", full, 1'b1);
        chk("ovf overflow", overflow, 1'b1);
        wait_drain(5 * 10 * CPB + 40);
        repeat (4) tick();
        chk("ovf sticky", overflow, 1'b1);
        chk("ovf busy end", busy, 1'b0);
        chk("ovf empty end", empty, 1'b1);

        do_reset();
        chk("overflow cleared", overflow, 1'b0);

        // Reset in the middle of a 0x00 frame.
        mon_en = 1'b0;
        write_byte(8'h00);
        tick();
        tick();
        chk("mid-rst start bit", tx_out, 1'b0);
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-rst tx", tx_out, 1'b1);
        chk("mid-rst empty", empty, 1'b1);
        chk("mid-rst busy", busy, 1'b0);
        begin
            int bad = 0;
            for (int c = 0; c < 60; c++) begin
                if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
                tick();
            end
            chk("mid-rst quiet cycles bad", bad, 0);
        end
        mon_en = 1'b1;

        // Write landing on the edge that ends STOP with the FIFO empty.
        sb.push_back(8'h3C);
        sb.push_back(8'hC5);
        write_byte(8'h3C);
        repeat (40) tick();
        wr_en   = 1'b1;
        wr_data = 8'hC5;
        tick();
        wr_en = 1'b0;
        chk("stop-edge busy idle", busy, 1'b0);
        chk("stop-edge tx", tx_out, 1'b1);
        tick();
        chk("stop-edge idle gap tx", tx_out, 1'b1);
        chk("stop-edge busy popped", busy, 1'b1);
        tick();
        chk("stop-edge start bit", tx_out, 1'b0);
        wait_drain(10 * CPB + 20);
        repeat (4) tick();
        chk("final busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
